// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single register-file write port between the
// pipeline WB stage and a multi-cycle unit. Multi-cycle results are queued in
// an in-order FIFO. A one-cycle FORCE state drains the FIFO head when it has
// been starved too long, or when the FIFO is full while WB keeps writing.
module rf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wb_valid,
  input  logic [1:0]        wb_regdst,
  input  logic [4:0]        wb_rt,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [4:0]        mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  output logic              stall_o,
  input  logic [4:0]        chk_addr,
  output logic              chk_hit,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  SC_MAX_C = SC_W'(STARVE_LIMIT - 1);

  typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic [4:0]          fifo_addr_q [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];
  logic                rf_we_q, rf_we_d;
  logic [4:0]          rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  logic                fifo_empty, fifo_full, push, pop, grant, head_denied;
  logic [4:0]          wb_dest, grant_addr;
  logic [DATA_W-1:0]   grant_data;
  logic [PTR_W-1:0]    chk_idx;

  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  assign fifo_full  = (count_q == DEPTH_C);
  assign mc_ready   = ~fifo_full;
  assign push       = mc_valid & ~fifo_full;
  assign stall_o    = (state_q == ST_FORCE);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  // Decode the WB destination register from its RegDst code.
  always_comb begin
    wb_dest = 5'd0;
    case (wb_regdst)
      2'd0:    wb_dest = wb_rt;
      2'd1:    wb_dest = wb_rd;
      default: wb_dest = 5'd31;
    endcase
  end

  // Pick this cycle's port owner: WB first in NORMAL, FIFO head in FORCE.
  always_comb begin
    pop        = 1'b0;
    grant      = 1'b0;
    grant_addr = 5'd0;
    grant_data = {DATA_W{1'b0}};
    case (state_q)
      ST_NORMAL: begin
        if (wb_valid) begin
          grant      = 1'b1;
          grant_addr = wb_dest;
          grant_data = wb_data;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          grant      = 1'b1;
          grant_addr = fifo_addr_q[rd_ptr_q];
          grant_data = fifo_data_q[rd_ptr_q];
        end else begin
          grant      = 1'b0;
        end
      end
      ST_FORCE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          grant      = 1'b1;
          grant_addr = fifo_addr_q[rd_ptr_q];
          grant_data = fifo_data_q[rd_ptr_q];
        end else begin
          grant      = 1'b0;
        end
      end
      default: begin
        grant = 1'b0;
      end
    endcase
    head_denied = ~fifo_empty & ~pop;
  end

  // FIFO pointer and occupancy next-state; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Arbitration FSM next-state and saturating starvation counter.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_NORMAL: begin
        if (((starve_q == SC_MAX_C) && head_denied) || (fifo_full && wb_valid)) begin
          state_d = ST_FORCE;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_FORCE: state_d = ST_NORMAL;
      default:  state_d = ST_NORMAL;
    endcase
    if (pop || fifo_empty) begin
      starve_d = {SC_W{1'b0}};
    end else if (starve_q != SC_MAX_C) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Write-port output next-state; $0 writes are consumed but never enabled.
  always_comb begin
    rf_we_d    = grant && (grant_addr != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant) begin
      rf_waddr_d = grant_addr;
      rf_wdata_d = grant_data;
    end else begin
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // Hazard query: match chk_addr against occupied FIFO slots only.
  always_comb begin
    chk_hit = 1'b0;
    chk_idx = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      chk_idx = rd_ptr_q + PTR_W'(i);
      if ((count_q > CNT_W'(i)) && (chk_addr != 5'd0) &&
          (fifo_addr_q[chk_idx] == chk_addr)) begin
        chk_hit = 1'b1;
      end else begin
        chk_hit = chk_hit;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_NORMAL;
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      starve_q   <= {SC_W{1'b0}};
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mc_addr;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed testbench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        wb_valid;
  logic [1:0]  wb_regdst;
  logic [4:0]  wb_rt, wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        stall_o;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wport_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .wb_valid(wb_valid), .wb_regdst(wb_regdst), .wb_rt(wb_rt), .wb_rd(wb_rd),
    .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .stall_o(stall_o), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_regdst = 2'd0; wb_rt = 5'd0; wb_rd = 5'd0; wb_data = 32'h0;
    mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 32'h0; chk_addr = 5'd0;
  endtask

  logic [4:0]  exp_addr [5];
  logic [31:0] exp_data [5];
  logic [4:0]  probe [3];

  initial begin
    idle_inputs();
    Rst = 1'b1;
    tick();
    tick();
    // ---------------- reset state ----------------
    check_eq("rst_we", rf_we, 32'd0);
    check_eq("rst_stall", stall_o, 32'd0);
    check_eq("rst_ready", mc_ready, 32'd1);
    Rst = 1'b0;
    probe[0] = 5'd0; probe[1] = 5'd5; probe[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      chk_addr = probe[i];
      #1;
      check_eq("rst_chk_hit", chk_hit, 32'd0);
    end
    tick();

    // ---------------- WB path, RegDst decode ----------------
    wb_valid = 1'b1; wb_regdst = 2'd1; wb_rd = 5'd9; wb_rt = 5'd4; wb_data = 32'hDEADBEEF;
    tick();
    check_eq("wb_rd_we", rf_we, 32'd1);
    check_eq("wb_rd_addr", rf_waddr, 32'd9);
    check_eq("wb_rd_data", rf_wdata, 32'hDEADBEEF);
    wb_regdst = 2'd2; wb_data = 32'h12345678;
    tick();
    check_eq("wb_r31_we", rf_we, 32'd1);
    check_eq("wb_r31_addr", rf_waddr, 32'd31);
    check_eq("wb_r31_data", rf_wdata, 32'h12345678);
    wb_regdst = 2'd0; wb_rt = 5'd0; wb_data = 32'h0000AAAA;
    tick();
    check_eq("wb_r0_we", rf_we, 32'd0);
    wb_valid = 1'b0;
    tick();
    check_eq("idle_we", rf_we, 32'd0);

    // ---------------- single multi-cycle result ----------------
    mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'h11; chk_addr = 5'd5;
    #1;
    check_eq("mc_hit_before", chk_hit, 32'd0);
    tick();
    mc_valid = 1'b0;
    #1;
    check_eq("mc_hit_queued", chk_hit, 32'd1);
    check_eq("mc_we_queued", rf_we, 32'd0);
    tick();
    check_eq("mc_we", rf_we, 32'd1);
    check_eq("mc_addr", rf_waddr, 32'd5);
    check_eq("mc_data", rf_wdata, 32'h11);
    check_eq("mc_hit_after", chk_hit, 32'd0);

    // ---------------- starvation forces a drain ----------------
    wb_valid = 1'b1; wb_regdst = 2'd1; wb_rd = 5'd7; wb_data = 32'h77;
    mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h00C0FFEE; chk_addr = 5'd12;
    tick();
    mc_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_eq("starve_no_stall", stall_o, 32'd0);
      check_eq("starve_wb_addr", rf_waddr, 32'd7);
      tick();
    end
    check_eq("starve_stall", stall_o, 32'd1);
    check_eq("starve_hit", chk_hit, 32'd1);
    tick();
    check_eq("starve_stall_end", stall_o, 32'd0);
    check_eq("starve_pop_we", rf_we, 32'd1);
    check_eq("starve_pop_addr", rf_waddr, 32'd12);
    check_eq("starve_pop_data", rf_wdata, 32'h00C0FFEE);
    check_eq("starve_hit_gone", chk_hit, 32'd0);
    tick();
    check_eq("starve_wb_we", rf_we, 32'd1);
    check_eq("starve_wb_addr2", rf_waddr, 32'd7);
    check_eq("starve_wb_data", rf_wdata, 32'h77);
    wb_valid = 1'b0;
    tick();

    // ---------------- fill FIFO while WB busy ----------------
    wb_valid = 1'b1; wb_regdst = 2'd1; wb_rd = 5'd3; wb_data = 32'h33;
    for (int k = 0; k < 4; k++) begin
      mc_valid = 1'b1; mc_addr = 5'd20 + 5'(k); mc_data = 32'hA0 + 32'(k);
      #1;
      check_eq("fill_ready", mc_ready, 32'd1);
      tick();
    end
    mc_addr = 5'd24; mc_data = 32'hA4; chk_addr = 5'd23;
    #1;
    check_eq("full_ready", mc_ready, 32'd0);
    check_eq("full_hit_tail", chk_hit, 32'd1);
    check_eq("full_no_stall", stall_o, 32'd0);
    chk_addr = 5'd24;
    #1;
    check_eq("full_hit_rejected", chk_hit, 32'd0);
    tick();
    check_eq("full_force", stall_o, 32'd1);
    check_eq("full_force_ready", mc_ready, 32'd0);
    tick();
    check_eq("full_after_stall", stall_o, 32'd0);
    check_eq("full_after_ready", mc_ready, 32'd1);
    check_eq("full_pop_we", rf_we, 32'd1);
    check_eq("full_pop_addr", rf_waddr, 32'd20);
    check_eq("full_pop_data", rf_wdata, 32'hA0);
    tick();
    mc_valid = 1'b0; wb_valid = 1'b0;
    exp_addr[0] = 5'd3;  exp_data[0] = 32'h33;
    exp_addr[1] = 5'd21; exp_data[1] = 32'hA1;
    exp_addr[2] = 5'd22; exp_data[2] = 32'hA2;
    exp_addr[3] = 5'd23; exp_data[3] = 32'hA3;
    exp_addr[4] = 5'd24; exp_data[4] = 32'hA4;
    for (int j = 0; j < 5; j++) begin
      check_eq("order_we", rf_we, 32'd1);
      check_eq("order_addr", rf_waddr, 32'(exp_addr[j]));
      check_eq("order_data", rf_wdata, exp_data[j]);
      tick();
    end
    check_eq("drained_we", rf_we, 32'd0);
    check_eq("drained_ready", mc_ready, 32'd1);

    // ---------------- reset with queued entries, FORCE pending ----------------
    wb_valid = 1'b1; wb_regdst = 2'd1; wb_rd = 5'd3; wb_data = 32'h55;
    for (int k = 0; k < 3; k++) begin
      mc_valid = 1'b1; mc_addr = 5'd30 - 5'(k); mc_data = 32'hB0 + 32'(k);
      tick();
    end
    mc_valid = 1'b0; chk_addr = 5'd30;
    for (int c = 3; c < 8; c++) begin
      tick();
    end
    check_eq("prerst_stall", stall_o, 32'd0);
    check_eq("prerst_hit", chk_hit, 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0; wb_valid = 1'b0;
    #1;
    check_eq("midrst_stall", stall_o, 32'd0);
    check_eq("midrst_we", rf_we, 32'd0);
    check_eq("midrst_ready", mc_ready, 32'd1);
    check_eq("midrst_hit", chk_hit, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("postrst_we", rf_we, 32'd0);
      check_eq("postrst_stall", stall_o, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between the pipeline WB stage and a multi-cycle execution unit (mul/div) whose results arrive out of band.
- Resolves the WB destination from its RegDst code (rt / rd / $31) and buffers multi-cycle results in a small FIFO.
- Grants the port each cycle and forces a one-cycle pipeline stall when buffered results starve.
- Provides a pending-write check so the hazard logic can stall readers of registers still queued.

Parameters:
DEPTH, 4, multi-cycle result FIFO entries (power of 2, ≥2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may be denied before a forced drain
DATA_W, 32, write data width

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  synchronous, active-high reset
wb_valid  in  1  WB stage holds an instruction writing the register file
wb_regdst  in  2  0=rt, 1=rd, 2 or 3=$31
wb_rt  in  5  rt field
wb_rd  in  5  rd field
wb_data  in  DATA_W  WB write data
mc_valid  in  1  multi-cycle result offered
mc_ready  out  1  FIFO can accept (= not full)
mc_addr  in  5  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle result
stall_o  out  1  WB not consumed this cycle; pipeline holds
chk_addr  in  5  register address queried by hazard logic
chk_hit  out  1  chk_addr nonzero and matches any valid FIFO entry
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  write address (registered)
rf_wdata  out  DATA_W  write data (registered)

Behaviour:
- Reset: FIFO empty (rd/wr ptr, count = 0), state NORMAL, starve_cnt = 0, rf_we/rf_waddr/rf_wdata = 0, stall_o = 0, mc_ready = 1.
- FIFO push: mc_valid && mc_ready. mc_ready = (count != DEPTH), combinational. Pointers wrap modulo DEPTH. Simultaneous push and pop: count is unchanged.
- WB destination: regdst 0 → wb_rt, 1 → wb_rd, 2/3 → 5'd31.
- States: NORMAL, FORCE. stall_o = (state == FORCE), Moore.
- NORMAL grant:
  - wb_valid → WB wins.
  - else FIFO non-empty → pop head.
  - else no write.
- FORCE grant: pop FIFO head, WB not consumed (pipeline held by stall_o). Always returns to NORMAL next cycle. starve_cnt clears.
- NORMAL→FORCE when either condition holds at the clock edge:
  - starve_cnt == STARVE_LIMIT-1 and the head is denied this cycle.
  - count == DEPTH and wb_valid.
- starve_cnt: +1 each cycle the FIFO is non-empty and the head is not popped. Clears on pop, when empty, or on reset. Saturates at STARVE_LIMIT-1.
- Write output: granted entry registered next edge (1-cycle latency). rf_we = 1 only if the granted address != 0. Writes to $0 are consumed (popped/accepted) with rf_we = 0. No grant → rf_we = 0, addr/data hold last value.
- Ordering: FIFO strictly in-order. A WB grant and a FIFO pop never occur in the same cycle.
- chk_hit: combinational over valid entries only (ptr/count based), excludes the entry being popped this cycle only after the edge.
- Reset mid-operation: queued results are discarded, FORCE is abandoned, and there is no rf_we pulse in the reset cycle or the cycle after.

Test Plan:
- Reset → rf_we=0, stall_o=0, mc_ready=1, chk_hit=0 for any chk_addr.
- wb_valid=1, regdst=1, rd=9, data=0xDEADBEEF (FIFO empty) → next cycle rf_we=1, waddr=9, wdata=0xDEADBEEF. Repeat with regdst=2 → waddr=31. Repeat with regdst=0, rt=0 → rf_we=0.
- Push mc_addr=5/data=0x11 with wb_valid=0 → entry popped next cycle, rf_we=1 addr 5 data 0x11. chk_addr=5 shows hit=1 only while the entry is queued.
- Push one entry, hold wb_valid=1 continuously → stall_o=1 in exactly the 9th cycle after the push (STARVE_LIMIT=8). That cycle writes the FIFO entry, the following cycle writes WB data, and starve_cnt restarts.
- Fill 4 entries while wb_valid=1 → mc_ready=0 at count 4, then FORCE pops. mc_valid held high is not accepted until mc_ready=1. Write order matches push order.
- Assert Rst with 3 queued entries and FORCE pending → no writes of queued data afterwards, mc_ready=1, stall_o=0.
